// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for the ALU command sequencer: opcode encodings,
// the queued command record and opcode classification helpers.
package alu_cmd_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_AND   = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0001;
  localparam logic [OP_W-1:0] OP_NOT   = 4'b0010;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_NAND  = 4'b0100;
  localparam logic [OP_W-1:0] OP_NOR   = 4'b0101;
  localparam logic [OP_W-1:0] OP_XNOR  = 4'b0110;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b1000;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b1001;
  localparam logic [OP_W-1:0] OP_SHR   = 4'b1010;
  localparam logic [OP_W-1:0] OP_SHL   = 4'b1011;
  localparam logic [OP_W-1:0] OP_CLEAR = 4'b1111;

  // One queued command as it sits in the FIFO (36 bits).
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_cmd_t;

  // 0111 and 1100-1110 have no ALU meaning.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return !(op == 4'b0111 || op == 4'b1100 || op == 4'b1101 || op == 4'b1110);
  endfunction

  // Only the adder ops produce a meaningful overflow flag.
  function automatic logic op_is_arith(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_fifo.sv
// Synchronous command FIFO with registered occupancy count; simultaneous
// push and pop are both honoured.
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage write; the array itself carries no reset.
  // NOTE: memory contents are never reset -- validity is tracked by count, and leaving the array out of reset keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally modulo DEPTH (power of 2); count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Command-side master for the 16-bit ALU: pops queued commands one at a
// time, drives the ALU inputs, waits out the operand register latency,
// returns result/overflow over valid/ready and then forces a CLEAR cycle.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int ALU_LAT   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(ALU_LAT + 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_CLR} state_t;

  state_t                   state;
  logic [CNT_W-1:0]         wait_cnt;
  alu_cmd_t                 push_cmd;
  alu_cmd_t                 head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(CMD_DEPTH):0] fifo_count;
  logic                     fifo_pop;

  assign push_cmd  = '{op: cmd_op, a: cmd_a, b: cmd_b};
  assign cmd_ready = !fifo_full;
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign busy      = (state != S_IDLE) || (fifo_count != '0);

  alu_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH ($bits(alu_cmd_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid),
    .wdata (push_cmd),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sequencer FSM: issue, wait for the ALU, hold the response, then CLEAR.
  // NOTE: every register here is assigned with <= so all next-state values are computed from pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      alu_opcode <= OP_CLEAR;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_ovf    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          alu_opcode <= OP_CLEAR;
          alu_a      <= '0;
          alu_b      <= '0;
          if (!fifo_empty) begin
            if (op_legal(head.op)) begin
              alu_opcode <= head.op;
              alu_a      <= head.a;
              alu_b      <= head.b;
              wait_cnt   <= CNT_W'(ALU_LAT);
              state      <= S_WAIT;
            end else begin
              // Illegal op never reaches the ALU; answer immediately.
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_ovf   <= 1'b0;
              rsp_err   <= 1'b1;
              state     <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= alu_result;
            rsp_ovf   <= op_is_arith(alu_opcode) && alu_overflow;
            rsp_err   <= 1'b0;
            state     <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid  <= 1'b0;
            alu_opcode <= OP_CLEAR;
            alu_a      <= '0;
            alu_b      <= '0;
            state      <= S_CLR;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
